// File: rtl/seven_seg_dual_mux.sv
// seven_seg_dual_mux: two-digit common-anode 7-segment refresh driver.
//
// Sequence: L_ON -> L_DEAD -> R_ON -> R_DEAD -> L_ON. Each *_ON state lasts
// REFRESH_CYCLES clocks and each *_DEAD state lasts DEAD_CYCLES clocks, with
// both anodes off. Both input digits are captured together on entry to L_ON,
// so a frame always shows one consistent pair. All outputs are registered and
// change only on state transitions.
//
// Optional build macro: DISP_LEADING_BLANK_EN
//   When it is defined, a captured left digit of 0 keeps the left position
//   dark during L_ON. Timing and frame_tick are unchanged.
module seven_seg_dual_mux #(
  parameter int REFRESH_CYCLES = 24000,
  parameter int DEAD_CYCLES    = 64,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,       // asynchronous, active-low
  input  logic [3:0] left,
  input  logic [3:0] right,
  output logic [6:0] seg,         // active-low, {g,f,e,d,c,b,a}
  output logic [1:0] an,          // active-low, an[1]=left, an[0]=right
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    L_ON   = 2'd0,
    L_DEAD = 2'd1,
    R_ON   = 2'd2,
    R_DEAD = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] REF_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [6:0]       SEG_BLANK = 7'h7F;
  localparam logic [1:0]       AN_OFF    = 2'b11;
  localparam logic [1:0]       AN_LEFT   = 2'b01;
  localparam logic [1:0]       AN_RIGHT  = 2'b10;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       sh_l_q;
  logic [3:0]       sh_r_q;
  logic [6:0]       seg_q;
  logic [1:0]       an_q;
  logic             tick_q;

  logic             cnt_last_d;
  logic             left_dark_d;

  // Active-low hex to 7-segment decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110;
      4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;
      default: dec = 7'b0001110;
    endcase
  endfunction

  // Last cycle of the current state: the limit depends on lit vs. dead phase.
  always_comb begin
    cnt_last_d = 1'b0;
    if (state_q == L_ON || state_q == R_ON) cnt_last_d = (cnt_q == REF_LAST);
    else                                    cnt_last_d = (cnt_q == DEAD_LAST);
  end

`ifdef DISP_LEADING_BLANK_EN
  // The digit being captured this edge is the raw input, so test it directly.
  assign left_dark_d = (left == 4'h0);
`else
  assign left_dark_d = 1'b0;
`endif

  // Phase counter, sequencing, frame capture and registered display outputs.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= R_DEAD;
      cnt_q   <= '0;
      sh_l_q  <= 4'h0;
      sh_r_q  <= 4'h0;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (!cnt_last_d) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
        case (state_q)
          R_DEAD: begin
            state_q <= L_ON;
            sh_l_q  <= left;
            sh_r_q  <= right;
            tick_q  <= 1'b1;
            if (left_dark_d) begin
              an_q  <= AN_OFF;
              seg_q <= SEG_BLANK;
            end else begin
              an_q  <= AN_LEFT;
              seg_q <= dec(left);
            end
          end
          L_ON: begin
            state_q <= L_DEAD;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
          end
          L_DEAD: begin
            state_q <= R_ON;
            an_q    <= AN_RIGHT;
            seg_q   <= dec(sh_r_q);
          end
          R_ON: begin
            state_q <= R_DEAD;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
          end
          default: begin
            state_q <= R_DEAD;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
          end
        endcase
      end
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_dual_mux.sv
// Self-checking bench for seven_seg_dual_mux with REFRESH_CYCLES=8,
// DEAD_CYCLES=2 (frame period 20). Outputs are sampled on the falling edge.
// Honours DISP_LEADING_BLANK_EN when the bench is built with it defined.
module tb_seven_seg_dual_mux;

  localparam int REF   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = 2 * (REF + DEAD);

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] left;
  logic [3:0] right;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  seven_seg_dual_mux #(
    .REFRESH_CYCLES(REF),
    .DEAD_CYCLES   (DEAD),
    .CNT_W         (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .left      (left),
    .right     (right),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Hand-written segment table, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] exp_dec(input logic [3:0] d);
    case (d)
      4'h0: exp_dec = 7'b1000000;
      4'h1: exp_dec = 7'b1111001;
      4'h2: exp_dec = 7'b0100100;
      4'h3: exp_dec = 7'b0110000;
      4'h4: exp_dec = 7'b0011001;
      4'h5: exp_dec = 7'b0010010;
      4'h6: exp_dec = 7'b0000010;
      4'h7: exp_dec = 7'b1111000;
      4'h8: exp_dec = 7'b0000000;
      4'h9: exp_dec = 7'b0010000;
      4'hA: exp_dec = 7'b0001000;
      4'hB: exp_dec = 7'b0000011;
      4'hC: exp_dec = 7'b1000110;
      4'hD: exp_dec = 7'b0100001;
      4'hE: exp_dec = 7'b0000110;
      default: exp_dec = 7'b0001110;
    endcase
  endfunction

  function automatic logic [1:0] exp_left_an(input logic [3:0] d);
`ifdef DISP_LEADING_BLANK_EN
    exp_left_an = (d == 4'h0) ? 2'b11 : 2'b01;
`else
    exp_left_an = (d == 4'h0) ? 2'b01 : 2'b01;
`endif
  endfunction

  function automatic logic [6:0] exp_left_seg(input logic [3:0] d);
`ifdef DISP_LEADING_BLANK_EN
    exp_left_seg = (d == 4'h0) ? 7'h7F : exp_dec(d);
`else
    exp_left_seg = exp_dec(d);
`endif
  endfunction

  // Continuous safety properties: never both anodes, dark means blank segments.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (an === 2'b00 || (an === 2'b11 && seg !== 7'h7F) || $isunknown(an)) begin
        errors++;
        $display("FAIL monitor t=%0t: an=%b seg=%b (need an!=00, and seg=1111111 when an=11)",
                 $time, an, seg);
      end
    end
  end

  // One-sample comparison of all three outputs.
  task automatic cmp(input string name, input int idx,
                     input logic [1:0] e_an, input logic [6:0] e_seg, input logic e_tick);
    checks++;
    if (an !== e_an || seg !== e_seg || frame_tick !== e_tick) begin
      errors++;
      $display("FAIL %s idx=%0d: an=%b seg=%b tick=%b, expected an=%b seg=%b tick=%b",
               name, idx, an, seg, frame_tick, e_an, e_seg, e_tick);
    end
  endtask

  // Check one full frame; the next falling edge must be the first L_ON cycle.
  // Optionally change the inputs right after sample chg_at.
  task automatic check_frame(input string name, input logic [3:0] l, input logic [3:0] r,
                             input int chg_at, input logic [3:0] nl, input logic [3:0] nr);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i < REF)                       cmp(name, i, exp_left_an(l), exp_left_seg(l), i == 0);
      else if (i < REF + DEAD)           cmp(name, i, 2'b11, 7'h7F, 1'b0);
      else if (i < 2 * REF + DEAD)       cmp(name, i, 2'b10, exp_dec(r), 1'b0);
      else                               cmp(name, i, 2'b11, 7'h7F, 1'b0);
      if (i == chg_at) begin
        left  = nl;
        right = nr;
      end
    end
  endtask

  // Release just after a rising edge, then expect DEAD blank cycles.
  task automatic release_and_check_dead(input string name);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < DEAD; i++) begin
      @(negedge clk);
      cmp(name, i, 2'b11, 7'h7F, 1'b0);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    left  = 4'h1;
    right = 4'hA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("reset_hold", i, 2'b11, 7'h7F, 1'b0);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_reset_sequence;
    release_and_check_dead("reset_dead");
    check_frame("reset_frame1", 4'h1, 4'hA, -1, 4'h0, 4'h0);
    check_frame("reset_frame2", 4'h1, 4'hA, -1, 4'h0, 4'h0);
  endtask

  task automatic test_mid_frame;
    left  = 4'h1;
    right = 4'h1;
    check_frame("midframe_old", 4'h1, 4'h1, 3, 4'h1, 4'h8);
    check_frame("midframe_new", 4'h1, 4'h8, -1, 4'h0, 4'h0);
  endtask

  task automatic test_decode;
    logic [3:0] d;
    left = 4'h0;
    for (int k = 0; k < 16; k++) begin
      d = 4'(k);
      check_frame("decode", d, 4'h8, REF + DEAD + 2, d + 4'h1, 4'h8);
    end
  endtask

  task automatic test_async_reset;
    left  = 4'h2;
    right = 4'h3;
    for (int i = 0; i < REF + DEAD + 3; i++) @(negedge clk);
    checks++;
    if (an !== 2'b10) begin
      errors++;
      $display("FAIL async_pre: an=%b, expected 10 (inside R_ON)", an);
    end
    #2 reset = 1'b0;
    #1;
    cmp("async_immediate", 0, 2'b11, 7'h7F, 1'b0);
    @(negedge clk);
    cmp("async_hold", 1, 2'b11, 7'h7F, 1'b0);
    release_and_check_dead("async_dead");
    check_frame("async_frame", 4'h2, 4'h3, -1, 4'h0, 4'h0);
  endtask

  task automatic test_leading_blank;
    left  = 4'h0;
    right = 4'h5;
    check_frame("leading_blank", 4'h0, 4'h5, -1, 4'h0, 4'h0);
  endtask

  initial begin
    test_reset();
    test_reset_sequence();
    test_mid_frame();
    test_decode();
    test_async_reset();
    test_leading_blank();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound in case sequencing never progresses.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary, errors=%0d", errors);
    $fatal(1);
  end

endmodule
